// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA pixel path: free-running h/v counters
// with registered sync, draw-enable, new-frame pulse and frame counter.
module vga_timing_gen #(
  parameter int unsigned ACTIVE_H      = 1024,
  parameter int unsigned H_FRONT_PORCH = 24,
  parameter int unsigned H_SYNC_WIDTH  = 136,
  parameter int unsigned H_BACK_PORCH  = 160,
  parameter int unsigned ACTIVE_V      = 768,
  parameter int unsigned V_FRONT_PORCH = 3,
  parameter int unsigned V_SYNC_WIDTH  = 6,
  parameter int unsigned V_BACK_PORCH  = 29,
  parameter int unsigned FPS           = 60
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        new_frame_out,
  output logic [5:0]  frame_count_out
);

  localparam int unsigned H_TOTAL  = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int unsigned V_TOTAL  = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int unsigned HS_START = ACTIVE_H + H_FRONT_PORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNC_WIDTH;
  localparam int unsigned VS_START = ACTIVE_V + V_FRONT_PORCH;
  localparam int unsigned VS_END   = VS_START + V_SYNC_WIDTH;

  if (H_TOTAL > 2048) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (FPS > 64) begin : g_bad_fps
    $error("vga_timing_gen: FPS exceeds 64");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        new_frame_q, new_frame_d;
  logic [5:0]  frame_q, frame_d;

  // Flags are decoded from the next counts so they land on the same edge
  // as the counts they describe; one-bit-wider compares avoid wrap at 2048/1024.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == 11'(H_TOTAL - 1)) begin
      hcount_d = '0;
      if (vcount_q == 10'(V_TOTAL - 1)) begin
        vcount_d = '0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end

    hsync_d     = ({1'b0, hcount_d} >= 12'(HS_START)) && ({1'b0, hcount_d} < 12'(HS_END));
    vsync_d     = ({1'b0, vcount_d} >= 11'(VS_START)) && ({1'b0, vcount_d} < 11'(VS_END));
    active_d    = ({1'b0, hcount_d} < 12'(ACTIVE_H)) && ({1'b0, vcount_d} < 11'(ACTIVE_V));
    new_frame_d = ({1'b0, hcount_d} == 12'(ACTIVE_H)) && ({1'b0, vcount_d} == 11'(ACTIVE_V));

    frame_d = frame_q;
    if (new_frame_d) begin
      frame_d = (frame_q == 6'(FPS - 1)) ? '0 : frame_q + 6'd1;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      active_q    <= 1'b0;
      new_frame_q <= 1'b0;
      frame_q     <= '0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      active_q    <= active_d;
      new_frame_q <= new_frame_d;
      frame_q     <= frame_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign active_draw_out = active_q;
  assign new_frame_out   = new_frame_q;
  assign frame_count_out = frame_q;

endmodule
